// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding and the
// oversample tick divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Rounded clk_hz / (baud * oversample).
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        int den;
        den = baud * oversample;
        return (clk_hz + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: show-ahead FIFO with occupancy count and a registered overrun
// pulse. A push into a full FIFO succeeds only when a pop happens that clk.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_rd_valid,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overrun
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overrun;
    logic             w_full;
    logic             w_rd;
    logic             w_wr;

    assign w_full = (r_count == (AW+1)'(DEPTH));
    assign w_rd   = i_rd_en && (r_count != '0);
    assign w_wr   = i_wr_en && (!w_full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_wr_en && w_full && !w_rd;
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is masked while empty so stale storage never shows on rd_data.
    assign o_rd_valid = (r_count != '0);
    assign o_rd_data  = o_rd_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count    = r_count;
    assign o_overrun  = r_overrun;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver feeding a show-ahead FIFO.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
//
// state  | meaning
// IDLE   | line idle, waiting for a low synchronised RX
// START  | half-bit wait, confirm start bit still low
// DATA   | sample DATA_BITS mid-bit, LSB first
// PARITY | sample and check the parity bit (UART_RX_PARITY_EN only)
// STOP   | check stop bit(s); on a low stop, wait for the line to go high
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          RX,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);
    localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SMP_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DIV < 1) begin : g_bad_cfg
        $error("uart_rx_fifo: illegal parameter set");
    end

    uart_state_t          r_state, w_state_nxt;
    logic                 r_rx_meta, r_rx_sync;
    logic [DIV_W-1:0]     r_div_cnt;
    logic [SMP_W-1:0]     r_smp_cnt, w_smp_nxt;
    logic [BIT_W-1:0]     r_bit_cnt, w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_bad, w_bad_nxt;
    logic                 r_frame_err, w_fe;
    logic                 w_tick, w_sample, w_push;
`ifdef UART_RX_PARITY_EN
    logic                 r_parity_err, w_pe;
`endif

    assign w_tick   = (r_div_cnt == '0);
    assign w_sample = w_tick && (r_smp_cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_div_cnt   <= '0;
            r_state     <= IDLE;
            r_smp_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_bad       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_meta   <= RX;
            r_rx_sync   <= r_rx_meta;
            r_div_cnt   <= w_tick ? DIV_W'(DIV - 1) : r_div_cnt - 1'b1;
            r_state     <= w_state_nxt;
            r_smp_cnt   <= w_smp_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_bad       <= w_bad_nxt;
            r_frame_err <= w_fe;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_smp_nxt   = r_smp_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_bad_nxt   = r_bad;
        w_push      = 1'b0;
        w_fe        = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_pe        = 1'b0;
`endif
        // Sample timer reloads a full bit after every terminal count.
        if (r_state != IDLE && w_tick)
            w_smp_nxt = (r_smp_cnt == '0) ? SMP_W'(OVERSAMPLE - 1) : r_smp_cnt - 1'b1;

        case (r_state)
            IDLE: begin
                w_smp_nxt = SMP_W'(OVERSAMPLE / 2 - 1);
                w_bad_nxt = 1'b0;
                if (!r_rx_sync) w_state_nxt = START;
            end
            START: begin
                if (w_sample) begin
                    w_bit_nxt   = '0;
                    w_state_nxt = r_rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_sample) begin
                    w_shift_nxt = {r_rx_sync, r_shift[DATA_BITS-1:1]};
                    if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        w_bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_sample) begin
                    w_pe        = ((^r_shift) ^ r_rx_sync) != 1'(PARITY_ODD);
                    w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (r_bad) begin
                    if (r_rx_sync) w_state_nxt = IDLE;
                end else if (w_sample) begin
                    if (!r_rx_sync) begin
                        w_fe      = 1'b1;
                        w_bad_nxt = 1'b1;
                    end else if (r_bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        w_push      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) r_parity_err <= 1'b0;
        else        r_parity_err <= w_pe;
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign frame_err = r_frame_err;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (w_push),
        .i_wr_data  (r_shift),
        .i_rd_en    (rd_en),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .o_count    (fifo_count),
        .o_overrun  (overrun)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo: serial frames against a queue model of
// the receive FIFO plus expected error pulse counts.
module tb_uart_rx_fifo;
    localparam int CLK_HZ     = 3_200_000;
    localparam int BAUD       = 100_000;
    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int STOP_BITS  = 1;
    localparam int PARITY_ODD = 0;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT_CLKS   = CLK_HZ / BAUD;

    logic                          clk = 1'b0;
    logic                          reset = 1'b0;
    logic                          RX = 1'b1;
    logic                          rd_en = 1'b0;
    logic [DATA_BITS-1:0]          rd_data;
    logic                          rd_valid;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          frame_err, parity_err, overrun;

    uart_rx_fifo #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE),
        .STOP_BITS(STOP_BITS), .PARITY_ODD(PARITY_ODD), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .RX(RX), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .fifo_count(fifo_count), .frame_err(frame_err),
        .parity_err(parity_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DATA_BITS-1:0] q[$];
    int exp_fe = 0, exp_pe = 0, exp_ovr = 0;
    int n_fe = 0, n_pe = 0, n_ovr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulses are counted in clk cycles high, so a stretched pulse shows up too.
    always @(negedge clk) begin
        if (frame_err)  n_fe++;
        if (parity_err) n_pe++;
        if (overrun)    n_ovr++;
    end

    task automatic bit_time(input logic v);
        RX = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit stop_ok, input bit par_bad);
        bit_time(1'b0);
        for (int i = 0; i < DATA_BITS; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_time((^d) ^ (PARITY_ODD != 0) ^ par_bad);
        if (par_bad) exp_pe++;
`else
        if (par_bad) $display("note: parity flip ignored, parity not compiled");
`endif
        for (int s = 0; s < STOP_BITS; s++) bit_time(stop_ok);
        RX = 1'b1;
        if (!stop_ok) begin
            exp_fe++;
            repeat (2) bit_time(1'b1);
        end else if (q.size() == FIFO_DEPTH) begin
            exp_ovr++;
        end else begin
            q.push_back(d);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(fifo_count), 32'(q.size()));
        check({tag, ".valid"}, 32'(rd_valid), 32'(q.size() != 0));
        check({tag, ".data"}, 32'(rd_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        check({tag, ".frame_err"}, 32'(n_fe), 32'(exp_fe));
        check({tag, ".parity_err"}, 32'(n_pe), 32'(exp_pe));
        check({tag, ".overrun"}, 32'(n_ovr), 32'(exp_ovr));
    endtask

    task automatic pop(input string tag);
        if (q.size() == 0) begin
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            check({tag, ".empty_pop_count"}, 32'(fifo_count), 32'd0);
        end else begin
            check({tag, ".head"}, 32'(rd_data), 32'(q[0]));
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            void'(q.pop_front());
        end
        check({tag, ".post_count"}, 32'(fifo_count), 32'(q.size()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_BITS-1:0] d;
        int kind, npop;

        repeat (5) @(negedge clk);
        check("reset.frame_err", 32'(frame_err), 32'd0);
        check("reset.parity_err", 32'(parity_err), 32'd0);
        check("reset.overrun", 32'(overrun), 32'd0);
        check_state("reset");
        reset = 1'b1;
        repeat (2) bit_time(1'b1);

        send_frame(8'h32, 1'b1, 1'b0);
        check_state("t1");

        send_frame(8'h31, 1'b1, 1'b0);
        check_state("t2");
        pop("t2a");
        pop("t2b");
        check_state("t2_drained");

        for (int i = 0; i < 5; i++) send_frame(8'h40 + 8'(i), 1'b1, 1'b0);
        check_state("t3_full");
        for (int i = 0; i < 5; i++) pop("t3_drain");

        send_frame(8'hA5, 1'b0, 1'b0);
        check_state("t4_ferr");
        send_frame(8'h36, 1'b1, 1'b0);
        check_state("t4_next");
        pop("t4");

        RX = 1'b0;
        repeat (BIT_CLKS * 40 / 104) @(negedge clk);
        RX = 1'b1;
        repeat (2) bit_time(1'b1);
        check_state("t5_false_start");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h32, 1'b1, 1'b0);
        check_state("t6_par_ok");
        send_frame(8'h32, 1'b1, 1'b1);
        check_state("t6_par_bad");
        pop("t6a");
        pop("t6b");
`endif

        send_frame(8'h5A, 1'b1, 1'b0);
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        bit_time(1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        q.delete();
        check("rst_mid.frame_err", 32'(frame_err), 32'd0);
        check_state("rst_mid");
        RX = 1'b1;
        reset = 1'b1;
        repeat (12) bit_time(1'b1);
        check_state("rst_mid_idle");
        send_frame(8'hC3, 1'b1, 1'b0);
        check_state("rst_mid_next");

        for (int it = 0; it < 40; it++) begin
            d = DATA_BITS'($urandom);
            kind = int'($urandom_range(0, 7));
`ifdef UART_RX_PARITY_EN
            send_frame(d, kind != 0, $urandom_range(0, 3) == 0);
`else
            send_frame(d, kind != 0, 1'b0);
`endif
            check_state("rand_frame");
            npop = int'($urandom_range(0, 2));
            for (int p = 0; p < npop; p++) pop("rand_pop");
            repeat ($urandom_range(0, 2)) bit_time(1'b1);
        end

        while (q.size() != 0) pop("final_drain");
        pop("final_empty");
        check_state("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
